// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
// Picks the EX-stage operand sources (ALU A/B and store data) from the
// pipeline registers. Detects ID-stage load-use hazards and drives a small
// stall FSM that holds PC and IF/ID and bubbles ID/EX. A saturating counter
// of detected hazards is kept for performance debug.
module fwd_hazard_unit #(
  parameter int REG_AW     = 4,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_store,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic              exmem_wen,
  input  logic [REG_AW-1:0] exmem_waddr,
  input  logic              exmem_is_load,
  input  logic              memwb_wen,
  input  logic [REG_AW-1:0] memwb_waddr,
  input  logic              mem_busy,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic [1:0]        fwd_store,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_events
);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] CNT_LOAD  = 2'(LOAD_STALL - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       stall_q;
  logic       exmem_ok;
  logic       memwb_ok;
  logic       haz;
  logic       assist;

  // A stage is a usable source only if it writes a non-zero register; a load
  // in EX/MEM has no data yet, so it can never forward from there.
  always_comb begin
    exmem_ok = exmem_wen && (exmem_waddr != '0) && !exmem_is_load;
    memwb_ok = memwb_wen && (memwb_waddr != '0);
  end

  // Operand source selection, EX/MEM taking priority over MEM/WB.
  always_comb begin
    forwardA  = FWD_RF;
    forwardB  = FWD_RF;
    fwd_store = FWD_RF;
    if (exmem_ok && (exmem_waddr == ex_rs))      forwardA = FWD_EXMEM;
    else if (memwb_ok && (memwb_waddr == ex_rs)) forwardA = FWD_MEMWB;
    if (exmem_ok && (exmem_waddr == ex_rt))      forwardB = FWD_EXMEM;
    else if (memwb_ok && (memwb_waddr == ex_rt)) forwardB = FWD_MEMWB;
    if (ex_is_store) begin
      if (exmem_ok && (exmem_waddr == ex_rd))      fwd_store = FWD_EXMEM;
      else if (memwb_ok && (memwb_waddr == ex_rd)) fwd_store = FWD_MEMWB;
    end
  end

  // Load in ID/EX whose destination is read by the instruction in IF/ID.
  always_comb begin
    haz = ex_is_load && (ex_waddr != '0) &&
          ((id_use_rs && (id_rs == ex_waddr)) ||
           (id_use_rt && (id_rt == ex_waddr)));
  end

  // Same-cycle assist so the detection cycle itself is held; masked while
  // reset is asserted so the holds drop immediately on reset.
  always_comb begin
    assist      = (state == IDLE) && haz && !rst;
    pc_hold     = stall_q | assist;
    ifid_hold   = stall_q | assist;
    idex_bubble = stall_q | assist;
  end

  // Stall FSM: counts bubble cycles, freezes while memory is busy, and
  // tallies each accepted hazard with saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      stall_q      <= 1'b0;
      stall_events <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (haz && !mem_busy) begin
            state   <= STALL;
            cnt     <= CNT_LOAD;
            stall_q <= 1'b1;
            if (stall_events != '1) stall_events <= stall_events + 1'b1;
          end
        end
        STALL: begin
          if (!mem_busy) begin
            if (cnt == 2'd0) begin
              state   <= IDLE;
              stall_q <= 1'b0;
            end else begin
              cnt <= cnt - 2'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
